mips_control_fsm: RTL and testbench
===================================

# mips_control_fsm

Multi-cycle control unit for the MIPS subset datapath. Sequences each instruction through fetch, decode, execute, memory and write-back steps and drives every datapath select and write-enable, including the ALU second-operand select. A ready handshake lets it stall on a shared instruction/data memory. It also keeps a retired-instruction count and traps on unsupported opcodes.

## Interface
- No parameters.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- MemRead, MemWrite  out  1  memory request; held until mem_ready.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load instruction register.
- pc_en  out  1  PC load enable (already includes the branch condition).
- PCsource  out  2  next PC: 00 = ALU, 01 = ALUOut (branch), 10 = jump target.
- ALUsrc_a  out  1  0 = PC, 1 = read_d1.
- ALUsrc_b  out  2  00 = read_d2, 01 = constant 4, 10 = signExtended32, 11 = signExtended32<<2.
- ALUop  out  2  00 = add, 01 = sub, 10 = decode from funct.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- illegal_op  out  1  sticky trap flag.
- instr_count  out  32  retired instructions.

## Operation
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010. Any other opcode is illegal.
- States and their asserted outputs. Any output not listed is 0.
  - FETCH: MemRead, IorD=0, ALUsrc_a=0, ALUsrc_b=01, ALUop=00, PCsource=00.
    - IRWrite and pc_en are asserted only while mem_ready=1.
    - Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE: ALUsrc_a=0, ALUsrc_b=11, ALUop=00 (precomputes the branch target).
    - Next state by opcode: lw/sw → MEM_ADDR, R → R_EXEC, addi → I_EXEC, beq → BRANCH, j → JUMP, other → TRAP.
  - MEM_ADDR: ALUsrc_a=1, ALUsrc_b=10, ALUop=00. Next: lw → MEM_READ, sw → MEM_WRITE.
  - MEM_READ: MemRead, IorD=1. Waits for mem_ready, then goes to MEM_WB.
  - MEM_WB: RegWrite, RegDst=0, MemtoReg=1 → FETCH. Retires.
  - MEM_WRITE: MemWrite, IorD=1. Waits for mem_ready, then goes to FETCH. Retires on the mem_ready cycle.
  - R_EXEC: ALUsrc_a=1, ALUsrc_b=00, ALUop=10 → R_WB.
  - R_WB: RegWrite, RegDst=1, MemtoReg=0 → FETCH. Retires.
  - I_EXEC: ALUsrc_a=1, ALUsrc_b=10, ALUop=00 → I_WB.
  - I_WB: RegWrite, RegDst=0, MemtoReg=0 → FETCH. Retires.
  - BRANCH: ALUsrc_a=1, ALUsrc_b=00, ALUop=01, PCsource=01, pc_en=zero → FETCH. Retires.
  - JUMP: PCsource=10, pc_en=1 → FETCH. Retires.
  - TRAP: all control outputs 0, illegal_op=1. Stays in TRAP until reset.
- instr_count increments by 1 on each retire cycle and wraps from 0xFFFF_FFFF to 0.
- opcode is sampled only in DECODE and MEM_ADDR. The IR cannot change outside FETCH.

## Timing
- Reset: on a rising edge with rst_n=0:
  - state ← FETCH, instr_count ← 0, illegal_op ← 0.
  - While rst_n=0, every control output is forced to 0.
  - Reset mid-instruction abandons the instruction: no write is committed after the reset edge and no retire is counted.
- Latency with mem_ready always 1, in cycles from entering FETCH to the next FETCH:
  - lw = 5
  - sw, R-type, addi = 4
  - beq, j = 3
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
  - Request outputs stay stable while stalled.
  - pc_en, IRWrite and RegWrite stay 0 while stalled.
- mem_ready outside a memory state is ignored.
- The only combinational input-to-output paths are mem_ready→{IRWrite, pc_en} and zero→pc_en. All other outputs depend on state only.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode localparams;
  - ALUop, ALUsrc_b and PCsource encodings.
- One sub-module, mips_ctrl_decode: purely combinational state→output decode.
- The top level holds the state register, the next-state logic, instr_count, illegal_op and the reset gating.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 → all outputs 0, instr_count=0. First cycle after release is FETCH with MemRead=1, IRWrite=1, pc_en=1.
- lw (opcode 100011), mem_ready=1 → state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. RegWrite=1 with MemtoReg=1 in cycle 5. instr_count goes 0→1.
- R-type then sw with mem_ready low for 2 cycles in MEM_WRITE → R takes 4 cycles. sw takes 6 cycles with MemWrite held for 3 cycles. instr_count=2.
- beq with zero=1, then beq with zero=0 → pc_en=1/PCsource=01 in BRANCH for the first, pc_en=0 for the second. Each takes 3 cycles.
- Opcode 111111 → TRAP after DECODE. illegal_op=1 and all controls 0 for 10 cycles. rst_n=0 clears illegal_op.
- Reset asserted during MEM_READ stall, and instr_count preloaded to 0xFFFF_FFFF then retiring a j → no RegWrite after the reset edge and state=FETCH. The j retire wraps instr_count to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds the controller state encoding, supported opcodes, the encodings of the
// ALU/PC select fields and the bundle of datapath control signals.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RD2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pcsource;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control decode for the multi-cycle MIPS controller.
// Ports:
//   i_state     current controller state
//   i_mem_ready memory handshake, only gates IRWrite/pc_en in FETCH and retire
//               in MEM_WRITE
//   i_zero      ALU zero flag, folded into pc_en in BRANCH
//   o_ctrl      datapath control bundle
//   o_retire    an instruction completes at the end of this cycle
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_zero,
  output ctrl_t  o_ctrl,
  output logic   o_retire
);

  always_comb begin
    o_ctrl   = '0;
    o_retire = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.alusrc_b = SRCB_FOUR;
        o_ctrl.aluop    = ALUOP_ADD;
        o_ctrl.pcsource = PCSRC_ALU;
        o_ctrl.ir_write = i_mem_ready;
        o_ctrl.pc_en    = i_mem_ready;
      end
      // Branch target is precomputed here while the opcode is decoded.
      S_DECODE: begin
        o_ctrl.alusrc_b = SRCB_IMM_SH2;
        o_ctrl.aluop    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        o_ctrl.alusrc_a = 1'b1;
        o_ctrl.alusrc_b = SRCB_IMM;
        o_ctrl.aluop    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_retire          = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
        o_retire         = i_mem_ready;
      end
      S_R_EXEC: begin
        o_ctrl.alusrc_a = 1'b1;
        o_ctrl.alusrc_b = SRCB_RD2;
        o_ctrl.aluop    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
        o_retire         = 1'b1;
      end
      S_I_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_retire         = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrc_a = 1'b1;
        o_ctrl.alusrc_b = SRCB_RD2;
        o_ctrl.aluop    = ALUOP_SUB;
        o_ctrl.pcsource = PCSRC_ALUOUT;
        o_ctrl.pc_en    = i_zero;
        o_retire        = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pcsource = PCSRC_JUMP;
        o_ctrl.pc_en    = 1'b1;
        o_retire        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle control unit for the MIPS subset datapath.
// Sequences fetch/decode/execute/memory/write-back, stalls on the shared
// memory via mem_ready, counts retired instructions and traps on unsupported
// opcodes until reset.
//
//   state     | meaning
//   FETCH     | read instruction at PC, PC+4 -> PC when memory ready
//   DECODE    | opcode dispatch, branch target precompute
//   MEM_ADDR  | base + offset for lw/sw
//   MEM_READ  | data read, waits for mem_ready
//   MEM_WB    | MDR -> rt, retire
//   MEM_WRITE | data write, waits for mem_ready, retires on ready
//   R_EXEC    | ALU op from funct
//   R_WB      | ALUOut -> rd, retire
//   I_EXEC    | rs + imm
//   I_WB      | ALUOut -> rt, retire
//   BRANCH    | compare, conditional PC load, retire
//   JUMP      | PC <- jump target, retire
//   TRAP      | unsupported opcode, parked until reset
//
// Ports: clk, rst_n (synchronous active-low), opcode, zero, mem_ready in;
// datapath selects/enables, illegal_op and instr_count out.
module mips_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        pc_en,
  output logic [1:0]  PCsource,
  output logic        ALUsrc_a,
  output logic [1:0]  ALUsrc_b,
  output logic [1:0]  ALUop,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  state_t      r_state;
  logic [31:0] r_instr_count;
  logic        r_illegal_op;
  ctrl_t       w_ctrl;
  ctrl_t       w_ctrl_out;
  logic        w_retire;

  mips_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_zero      (zero),
    .o_ctrl      (w_ctrl),
    .o_retire    (w_retire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
      r_illegal_op  <= 1'b0;
    end else begin
      // Written every cycle so the counter always tracks its own current value.
      r_instr_count <= r_instr_count + {31'd0, w_retire};
      case (r_state)
        S_FETCH:     if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
            OP_RTYPE:     r_state <= S_R_EXEC;
            OP_ADDI:      r_state <= S_I_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            default: begin
              r_state      <= S_TRAP;
              r_illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR:  r_state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:    r_state <= S_R_WB;
        S_I_EXEC:    r_state <= S_I_WB;
        S_TRAP:      r_state <= S_TRAP;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // Controls are forced low for the whole time reset is held, not just after
  // the reset edge, so an abandoned instruction can never commit a write.
  assign w_ctrl_out  = rst_n ? w_ctrl : '0;

  assign MemRead     = w_ctrl_out.mem_read;
  assign MemWrite    = w_ctrl_out.mem_write;
  assign IorD        = w_ctrl_out.iord;
  assign IRWrite     = w_ctrl_out.ir_write;
  assign pc_en       = w_ctrl_out.pc_en;
  assign PCsource    = w_ctrl_out.pcsource;
  assign ALUsrc_a    = w_ctrl_out.alusrc_a;
  assign ALUsrc_b    = w_ctrl_out.alusrc_b;
  assign ALUop       = w_ctrl_out.aluop;
  assign RegDst      = w_ctrl_out.reg_dst;
  assign MemtoReg    = w_ctrl_out.mem_to_reg;
  assign RegWrite    = w_ctrl_out.reg_write;
  assign illegal_op  = r_illegal_op & rst_n;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm. The driver walks each instruction
// through the step list its class implies, pushes the control vector each step
// must show, and a negedge monitor pops and compares.
module tb_mips_control_fsm;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;

  typedef enum {P_FETCH, P_DECODE, P_ADDR, P_RD, P_LWB, P_WR, P_REX, P_RWB,
                P_IEX, P_IWB, P_BR, P_J, P_TRAP, P_RST} ph_t;

  typedef struct {
    int          cyc;
    ph_t         p;
    logic [15:0] ctl;
    logic [31:0] cnt;
    bit          chkc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        MemRead, MemWrite, IorD, IRWrite, pc_en, ALUsrc_a;
  logic        RegDst, MemtoReg, RegWrite, illegal_op;
  logic [1:0]  PCsource, ALUsrc_b, ALUop;
  logic [31:0] instr_count;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] model_cnt = 32'd0;
  bit          cnt_known = 1'b0;

  mips_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .pc_en(pc_en), .PCsource(PCsource), .ALUsrc_a(ALUsrc_a), .ALUsrc_b(ALUsrc_b),
    .ALUop(ALUop), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Required controls per step, straight from the per-step output list.
  function automatic logic [15:0] exp_ctl(input ph_t p, input logic mr, input logic z);
    logic mrd = 0, mwr = 0, iord = 0, irw = 0, pce = 0, asa = 0;
    logic rd = 0, m2r = 0, rw = 0, ill = 0;
    logic [1:0] pcs = 0, asb = 0, aop = 0;
    case (p)
      P_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pce = mr; end
      P_DECODE: asb = 2'b11;
      P_ADDR:   begin asa = 1; asb = 2'b10; end
      P_RD:     begin mrd = 1; iord = 1; end
      P_LWB:    begin rw = 1; m2r = 1; end
      P_WR:     begin mwr = 1; iord = 1; end
      P_REX:    begin asa = 1; aop = 2'b10; end
      P_RWB:    begin rw = 1; rd = 1; end
      P_IEX:    begin asa = 1; asb = 2'b10; end
      P_IWB:    rw = 1;
      P_BR:     begin asa = 1; aop = 2'b01; pcs = 2'b01; pce = z; end
      P_J:      begin pcs = 2'b10; pce = 1; end
      P_TRAP:   ill = 1;
      default:  ;
    endcase
    return {mrd, mwr, iord, irw, pce, pcs, asa, asb, aop, rd, m2r, rw, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 5))
      0: return T_R;
      1: return T_LW;
      2: return T_SW;
      3: return T_BEQ;
      4: return T_ADDI;
      default: return T_J;
    endcase
  endfunction

  task automatic push(input ph_t p, input logic mr, input logic z);
    exp_t e;
    e.cyc = cyc; e.p = p; e.ctl = exp_ctl(p, mr, z); e.cnt = model_cnt; e.chkc = cnt_known;
    sb.push_back(e);
  endtask

  task automatic step(input ph_t p, input logic mr, input logic z, input bit ret,
                      input logic [5:0] op);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = mr; zero = z; opcode = op;
    push(p, mr, z);
    if (ret) model_cnt = model_cnt + 32'd1;
  endtask

  task automatic step_rst();
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ready = rb(); zero = rb(); opcode = rop();
    push(P_RST, mem_ready, zero);
    model_cnt = 32'd0;
    cnt_known = 1'b1;
  endtask

  // fst: FETCH wait cycles, mst: data-memory wait cycles, z: zero flag in BRANCH
  task automatic do_instr(input logic [5:0] op, input int fst, input int mst, input logic z);
    for (int i = 0; i < fst; i++) step(P_FETCH, 1'b0, rb(), 0, rop());
    step(P_FETCH, 1'b1, rb(), 0, rop());
    step(P_DECODE, rb(), rb(), 0, op);
    case (op)
      T_LW: begin
        step(P_ADDR, rb(), rb(), 0, op);
        for (int i = 0; i < mst; i++) step(P_RD, 1'b0, rb(), 0, op);
        step(P_RD, 1'b1, rb(), 0, op);
        step(P_LWB, rb(), rb(), 1, op);
      end
      T_SW: begin
        step(P_ADDR, rb(), rb(), 0, op);
        for (int i = 0; i < mst; i++) step(P_WR, 1'b0, rb(), 0, op);
        step(P_WR, 1'b1, rb(), 1, op);
      end
      T_R: begin
        step(P_REX, rb(), rb(), 0, op);
        step(P_RWB, rb(), rb(), 1, op);
      end
      T_ADDI: begin
        step(P_IEX, rb(), rb(), 0, op);
        step(P_IWB, rb(), rb(), 1, op);
      end
      T_BEQ:   step(P_BR, rb(), z, 1, op);
      T_J:     step(P_J, rb(), rb(), 1, op);
      default: for (int i = 0; i < 10; i++) step(P_TRAP, rb(), rb(), 0, op);
    endcase
  endtask

  // Monitor: compare whatever the DUT shows against the entry queued for this cycle.
  initial begin
    exp_t e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_chk++;
        $display("FAIL stale_entry %s cyc=%0d never compared (now %0d)", e.p.name(), e.cyc, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        act = {MemRead, MemWrite, IorD, IRWrite, pc_en, PCsource, ALUsrc_a, ALUsrc_b,
               ALUop, RegDst, MemtoReg, RegWrite, illegal_op};
        n_chk++;
        if (act !== e.ctl || (e.chkc && instr_count !== e.cnt))
          $display("FAIL %s cyc=%0d ctl got=%h want=%h count got=%h want=%h",
                   e.p.name(), cyc, act, e.ctl, instr_count, e.chkc ? e.cnt : instr_count);
        else
          n_pass++;
      end
    end
  end

  initial begin
    repeat (3) step_rst();

    do_instr(T_LW, 0, 0, 1'b0);
    do_instr(T_R, 0, 0, 1'b0);
    do_instr(T_SW, 0, 2, 1'b0);
    do_instr(T_BEQ, 0, 0, 1'b1);
    do_instr(T_BEQ, 0, 0, 1'b0);
    do_instr(T_ADDI, 1, 0, 1'b0);
    do_instr(T_J, 0, 0, 1'b0);

    repeat (40) do_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3), rb());

    do_instr(6'b111111, 0, 0, 1'b0);
    repeat (2) step_rst();
    do_instr(T_LW, 1, 1, 1'b0);

    // Reset lands while a load is stalled on memory.
    step(P_FETCH, 1'b1, rb(), 0, rop());
    step(P_DECODE, rb(), rb(), 0, T_LW);
    step(P_ADDR, rb(), rb(), 0, T_LW);
    step(P_RD, 1'b0, rb(), 0, T_LW);
    step(P_RD, 1'b0, rb(), 0, T_LW);
    step_rst();

    // Counter preloaded to all-ones during a FETCH wait, then a jump retires.
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = rop();
    force dut.r_instr_count = 32'hFFFF_FFFF;
    model_cnt = 32'hFFFF_FFFF;
    push(P_FETCH, 1'b0, 1'b0);
    @(posedge clk); #1;
    release dut.r_instr_count;
    mem_ready = 1'b1; opcode = rop();
    push(P_FETCH, 1'b1, 1'b0);
    step(P_DECODE, rb(), rb(), 0, T_J);
    step(P_J, rb(), rb(), 1, T_J);

    repeat (6) do_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 2), rb());

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
